cmac_tx_pkt_arbiter: RTL and testbench
======================================

Name: cmac_tx_pkt_arbiter

Overview:
N-channel store-and-forward packet arbiter that feeds the CMAC TX AXIS port from several ERNIC-side AXIS sources (for example the QP send path and the pkt_gen test source).
- Packets are only released to CMAC once complete, so tx_unfout can never be caused by mid-packet bubbles.
- Oversize packets are dropped.
- New packets are gated by tx_enable, and sent/dropped statistics are kept.
- Sits between the ERNIC TX stream and the cmac_usplus_0 tx_axis_* interface, in the txusrclk2 domain.

Parameters:
NUM_CH, 2, number of input AXIS channels (1..8)
DATA_W, 512, tdata width in bits; tkeep width is DATA_W/8
FIFO_DEPTH, 64, packet buffer depth in beats; power of 2
MAX_PKT_BEATS, 32, largest accepted packet in beats; must be <= FIFO_DEPTH
CNT_W, 32, statistics counter width

Ports:
aclk  in  1  clock (txusrclk2)
aresetn  in  1  asynchronous active-low reset
s_axis_tdata  in  NUM_CH*DATA_W  channel i data in slice i
s_axis_tkeep  in  NUM_CH*DATA_W/8  byte enables per channel
s_axis_tvalid  in  NUM_CH  valid per channel
s_axis_tlast  in  NUM_CH  last per channel
s_axis_tready  out  NUM_CH  ready per channel
m_axis_tdata  out  DATA_W  to CMAC tx_axis_tdata
m_axis_tkeep  out  DATA_W/8  to CMAC
m_axis_tvalid  out  1  to CMAC
m_axis_tlast  out  1  to CMAC
m_axis_tuser  out  1  constant 0
m_axis_tready  in  1  from CMAC
tx_enable  in  1  packet-start gate (ctl_tx_enable / alignment)
pkt_sent_cnt  out  CNT_W  packets fully transmitted
pkt_drop_cnt  out  CNT_W  packets dropped as oversize
fifo_level  out  log2(FIFO_DEPTH)+1  beats currently held, committed plus uncommitted

Behaviour:
Reset:
- aresetn=0 clears all pointers, counters, grant and state asynchronously.
- All outputs are 0 during reset; s_axis_tready is 0.
- Reset mid-packet discards all buffered and in-flight data.

Input FSM:
- IDLE: round-robin over s_axis_tvalid, starting at the channel after the last grant. The grant registers in 1 cycle and the FSM moves to XFER. All s_axis_tready are 0 in IDLE.
- XFER: s_axis_tready[grant] = (fifo_level < FIFO_DEPTH); all other channels get 0.
  - Each accepted beat writes {tlast, tkeep, tdata} at wptr and increments beat_cnt.
  - Accepted tlast with beat_cnt+1 <= MAX_PKT_BEATS: commit (wptr_commit <= wptr+1), go to IDLE.
  - Accepted beat with beat_cnt+1 == MAX_PKT_BEATS and tlast=0: rewind wptr to wptr_commit, go to DROP.
- DROP: s_axis_tready[grant]=1; beats are discarded. On tlast, pkt_drop_cnt++ and go to IDLE.
- Stall rule: a full FIFO mid-packet stalls only. This is deadlock-free because committed data always drains.

Output side:
- The read side sees only committed data (rptr != wptr_commit).
- Registered FWFT output. The first beat of a packet appears on m_axis_tvalid exactly 2 cycles after its tlast beat is accepted, provided the FIFO was otherwise empty and tx_enable=1.
- A packet starts only if tx_enable=1 at its first beat. Once started it runs to tlast regardless of tx_enable.
- m_axis_tvalid stays high for every beat of a started packet; no bubbles while m_axis_tready=1.
- Output holds data stable while m_axis_tvalid=1 and m_axis_tready=0.
- pkt_sent_cnt increments on an m_axis tlast handshake.

Arithmetic and boundaries:
- Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- fifo_level = wptr - rptr.
- Commit and read in the same cycle are both honoured.
- Counters saturate at all-ones.
- Single-beat packets are legal.

Decomposition:
- Package cmac_tx_pkg: arbiter state enum (IDLE, XFER, DROP), PTR_W/KEEP_W derivation constants, round-robin next-grant function.
- Sub-module cmac_tx_pkt_fifo: simple dual-port RAM plus wptr/wptr_commit/rptr, with commit and rewind inputs and registered FWFT output.
- The top holds the arbiter FSM, output gating and counters.

Test Plan:
- ch0 sends one 9-beat packet, m_axis_tready=1, tx_enable=1 -> 9 contiguous output beats starting 2 cycles after input tlast; pkt_sent_cnt=1.
- ch0 and ch1 both valid continuously with 4-beat packets -> grants alternate 0,1,0,1; output order matches; no interleaving inside a packet.
- ch1 sends a 40-beat packet (MAX_PKT_BEATS=32) followed by a 3-beat packet -> pkt_drop_cnt=1, only the 3-beat packet is output, fifo_level returns to 0.
- tx_enable=0 while 2 packets are committed, then raised -> no output until raised; deasserting tx_enable mid-packet still completes that packet.
- m_axis_tready held 0 until fifo_level=64, then released -> s_axis_tready drops at full; all data is output intact, in order, with no gaps.
- aresetn pulsed low mid-XFER with 20 beats buffered -> all outputs 0; after release, a fresh 2-beat packet passes with counters starting from 0.

Source files
------------

// File: rtl/cmac_tx_pkg.sv
// Shared types and helpers for the CMAC TX packet arbiter: FSM states,
// width derivations and the round-robin grant search.
package cmac_tx_pkg;

    localparam int MAX_CH  = 8;
    localparam int GRANT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_DROP
    } arb_state_e;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int keep_w(input int data_w);
        return data_w / 8;
    endfunction

    // First requester after 'last', wrapping; the nearest candidate is checked last so it wins.
    function automatic logic [GRANT_W-1:0] rr_next(input logic [MAX_CH-1:0]  req,
                                                   input logic [GRANT_W-1:0] last,
                                                   input int                 num_ch);
        logic [GRANT_W-1:0] nxt;
        int                 idx;
        nxt = last;
        for (int i = num_ch; i >= 1; i--) begin
            idx = (int'(last) + i) % num_ch;
            if (req[idx[GRANT_W-1:0]]) nxt = idx[GRANT_W-1:0];
        end
        return nxt;
    endfunction

endpackage

// File: rtl/cmac_tx_pkt_fifo.sv
// Packet buffer with commit/rewind write pointer; the read side only sees
// committed packets and presents them through a registered FWFT stage.
module cmac_tx_pkt_fifo
    import cmac_tx_pkg::*;
#(
    parameter int WIDTH = 577,
    parameter int DEPTH = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    commit,
    input  logic                    rewind,
    input  logic                    rd_pop,
    output logic                    rd_valid,
    output logic [WIDTH-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    wptr_commit;
    logic [PW-1:0]    rptr;
    logic             load;

    // Refill the output stage whenever it is empty or being consumed this cycle.
    assign load  = (rptr != wptr_commit) && (!rd_valid || rd_pop);
    assign level = wptr - rptr;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr        <= '0;
            wptr_commit <= '0;
            rptr        <= '0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
        end else begin
            if (rewind)     wptr <= wptr_commit;
            else if (wr_en) wptr <= wptr + 1'b1;
            if (commit)     wptr_commit <= wptr + 1'b1;
            if (load) begin
                rptr     <= rptr + 1'b1;
                rd_data  <= mem[rptr[AW-1:0]];
                rd_valid <= 1'b1;
            end else if (rd_pop) begin
                rd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cmac_tx_pkt_arbiter.sv
// Store-and-forward N:1 AXIS packet arbiter feeding the CMAC TX port; drops
// oversize packets and gates packet starts with tx_enable.
module cmac_tx_pkt_arbiter
    import cmac_tx_pkg::*;
#(
    parameter int NUM_CH        = 2,
    parameter int DATA_W        = 512,
    parameter int FIFO_DEPTH    = 64,
    parameter int MAX_PKT_BEATS = 32,
    parameter int CNT_W         = 32
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [NUM_CH*DATA_W-1:0]      s_axis_tdata,
    input  logic [NUM_CH*DATA_W/8-1:0]    s_axis_tkeep,
    input  logic [NUM_CH-1:0]             s_axis_tvalid,
    input  logic [NUM_CH-1:0]             s_axis_tlast,
    output logic [NUM_CH-1:0]             s_axis_tready,
    output logic [DATA_W-1:0]             m_axis_tdata,
    output logic [DATA_W/8-1:0]           m_axis_tkeep,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tuser,
    input  logic                          m_axis_tready,
    input  logic                          tx_enable,
    output logic [CNT_W-1:0]              pkt_sent_cnt,
    output logic [CNT_W-1:0]              pkt_drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int KEEP_W = keep_w(DATA_W);
    localparam int PW     = ptr_w(FIFO_DEPTH);
    localparam int BW     = $clog2(MAX_PKT_BEATS + 1);
    localparam int FW     = 1 + KEEP_W + DATA_W;

    arb_state_e         state, state_nxt;
    logic [GRANT_W-1:0] grant, grant_nxt;
    logic [BW-1:0]      beat_cnt;
    logic [MAX_CH-1:0]  req;
    logic               sel_valid, sel_last;
    logic [DATA_W-1:0]  sel_data;
    logic [KEEP_W-1:0]  sel_keep;
    logic               not_full, wr_en, commit, rewind, drop_inc;
    logic               fifo_vld, mid_pkt, pop;
    logic [FW-1:0]      fifo_q;

    always_comb begin
        req                = '0;
        req[NUM_CH-1:0]    = s_axis_tvalid;
        sel_valid          = 1'b0;
        sel_last           = 1'b0;
        sel_data           = '0;
        sel_keep           = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant == GRANT_W'(i)) begin
                sel_valid = s_axis_tvalid[i];
                sel_last  = s_axis_tlast[i];
                sel_data  = s_axis_tdata[i*DATA_W +: DATA_W];
                sel_keep  = s_axis_tkeep[i*KEEP_W +: KEEP_W];
            end
        end
    end

    assign not_full = (fifo_level != PW'(FIFO_DEPTH));

    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        s_axis_tready = '0;
        wr_en         = 1'b0;
        commit        = 1'b0;
        rewind        = 1'b0;
        drop_inc      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|s_axis_tvalid) begin
                    grant_nxt = rr_next(req, grant, NUM_CH);
                    state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                for (int i = 0; i < NUM_CH; i++)
                    if (grant == GRANT_W'(i)) s_axis_tready[i] = not_full;
                if (sel_valid && not_full) begin
                    wr_en = 1'b1;
                    if (sel_last) begin
                        commit    = 1'b1;
                        state_nxt = ST_IDLE;
                    end else if (beat_cnt == BW'(MAX_PKT_BEATS - 1)) begin
                        // Oversize: forget what was written and swallow the rest.
                        rewind    = 1'b1;
                        state_nxt = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                for (int i = 0; i < NUM_CH; i++)
                    if (grant == GRANT_W'(i)) s_axis_tready[i] = 1'b1;
                if (sel_valid && sel_last) begin
                    drop_inc  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    cmac_tx_pkt_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (aclk),
        .rst_n    (aresetn),
        .wr_en    (wr_en),
        .wr_data  ({sel_last, sel_keep, sel_data}),
        .commit   (commit),
        .rewind   (rewind),
        .rd_pop   (pop),
        .rd_valid (fifo_vld),
        .rd_data  (fifo_q),
        .level    (fifo_level)
    );

    assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = fifo_q;
    // tx_enable only matters for the first beat; a started packet always finishes.
    assign m_axis_tvalid = fifo_vld & (mid_pkt | tx_enable);
    assign m_axis_tuser  = 1'b0;
    assign pop           = m_axis_tvalid & m_axis_tready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= ST_IDLE;
            grant        <= '0;
            beat_cnt     <= '0;
            mid_pkt      <= 1'b0;
            pkt_sent_cnt <= '0;
            pkt_drop_cnt <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            if (state == ST_IDLE) beat_cnt <= '0;
            else if (wr_en)       beat_cnt <= beat_cnt + 1'b1;
            if (pop) mid_pkt <= ~m_axis_tlast;
            if (pop && m_axis_tlast && !(&pkt_sent_cnt)) pkt_sent_cnt <= pkt_sent_cnt + 1'b1;
            if (drop_inc && !(&pkt_drop_cnt))            pkt_drop_cnt <= pkt_drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_cmac_tx_pkt_arbiter.sv
// Scoreboard bench for cmac_tx_pkt_arbiter: accepted input packets of legal
// length are queued as expected output beats and compared at the m_axis side.
module tb_cmac_tx_pkt_arbiter;

    localparam int NUM_CH   = 2;
    localparam int DATA_W   = 512;
    localparam int KEEP_W   = DATA_W / 8;
    localparam int DEPTH    = 64;
    localparam int MAX_PKT  = 32;
    localparam int CNT_W    = 32;
    localparam int CW       = 1 + KEEP_W + DATA_W;

    typedef struct packed {
        logic              last;
        logic [KEEP_W-1:0] keep;
        logic [DATA_W-1:0] data;
    } beat_t;

    logic                       aclk;
    logic                       aresetn;
    logic [NUM_CH*DATA_W-1:0]   s_axis_tdata;
    logic [NUM_CH*KEEP_W-1:0]   s_axis_tkeep;
    logic [NUM_CH-1:0]          s_axis_tvalid;
    logic [NUM_CH-1:0]          s_axis_tlast;
    logic [NUM_CH-1:0]          s_axis_tready;
    logic [DATA_W-1:0]          m_axis_tdata;
    logic [KEEP_W-1:0]          m_axis_tkeep;
    logic                       m_axis_tvalid;
    logic                       m_axis_tlast;
    logic                       m_axis_tuser;
    logic                       m_axis_tready;
    logic                       tx_enable;
    logic [CNT_W-1:0]           pkt_sent_cnt;
    logic [CNT_W-1:0]           pkt_drop_cnt;
    logic [$clog2(DEPTH):0]     fifo_level;

    cmac_tx_pkt_arbiter #(
        .NUM_CH        (NUM_CH),
        .DATA_W        (DATA_W),
        .FIFO_DEPTH    (DEPTH),
        .MAX_PKT_BEATS (MAX_PKT),
        .CNT_W         (CNT_W)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tready (m_axis_tready),
        .tx_enable     (tx_enable),
        .pkt_sent_cnt  (pkt_sent_cnt),
        .pkt_drop_cnt  (pkt_drop_cnt),
        .fifo_level    (fifo_level)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int    checks, errors, cyc;
    beat_t pend [NUM_CH][$];
    beat_t cur  [NUM_CH][$];
    beat_t exp_q [$];
    int    grant_log [$];
    int    exp_sent, exp_drop, out_beats, gap_cnt, hold_err, multi_rdy;
    int    tlast_cyc, first_out_cyc;
    bit    mid_out, prev_stall;
    beat_t prev_word;

    task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic beat_t mk_beat(input bit last);
        beat_t             b;
        logic [KEEP_W-1:0] kp;
        for (int k = 0; k < DATA_W / 32; k++) b.data[k*32 +: 32] = $urandom();
        kp = '1;
        if (last) kp = kp >> $urandom_range(0, KEEP_W - 1);
        b.keep = kp;
        b.last = last;
        return b;
    endfunction

    task automatic enq(input int ch, input int n);
        for (int i = 0; i < n; i++) pend[ch].push_back(mk_beat(i == n - 1));
    endtask

    function automatic bit busy();
        bit b;
        b = (exp_q.size() != 0) || mid_out;
        for (int ch = 0; ch < NUM_CH; ch++) if (pend[ch].size() != 0) b = 1'b1;
        return b;
    endfunction

    // One cycle: sample both interfaces mid-cycle, then drive the next input beats after the edge.
    task automatic step();
        beat_t e;
        beat_t w;
        @(negedge aclk);
        cyc++;
        if ($countones(s_axis_tready) > 1) multi_rdy++;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (s_axis_tvalid[ch] && s_axis_tready[ch]) begin
                cur[ch].push_back(pend[ch][0]);
                pend[ch].pop_front();
                if (cur[ch][cur[ch].size()-1].last) begin
                    if (cur[ch].size() <= MAX_PKT) begin
                        for (int k = 0; k < cur[ch].size(); k++) exp_q.push_back(cur[ch][k]);
                        grant_log.push_back(ch);
                        exp_sent++;
                    end else begin
                        exp_drop++;
                    end
                    cur[ch].delete();
                    tlast_cyc = cyc;
                end
            end
        end
        w = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_beat", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_beat", w, e);
            end
            if (!mid_out) first_out_cyc = cyc;
            mid_out = !m_axis_tlast;
            out_beats++;
        end else if (mid_out && m_axis_tready) begin
            gap_cnt++;
        end
        if (prev_stall && (!m_axis_tvalid || w != prev_word)) hold_err++;
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_word  = w;
        @(posedge aclk);
        #1;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (pend[ch].size() != 0) begin
                s_axis_tvalid[ch]                  = 1'b1;
                s_axis_tdata[ch*DATA_W +: DATA_W]  = pend[ch][0].data;
                s_axis_tkeep[ch*KEEP_W +: KEEP_W]  = pend[ch][0].keep;
                s_axis_tlast[ch]                   = pend[ch][0].last;
            end else begin
                s_axis_tvalid[ch] = 1'b0;
                s_axis_tlast[ch]  = 1'b0;
            end
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (busy() && n < 3000) begin
            step();
            n++;
        end
        if (n >= 3000) chk({tag, "_drain_timeout"}, 1, 0);
        repeat (3) step();
    endtask

    initial begin
        int base, s0, n;
        aresetn       = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tvalid = '1;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b1;
        tx_enable     = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_m_tvalid", m_axis_tvalid, 0);
        chk("rst_s_tready", s_axis_tready, 0);
        chk("rst_m_tdata", m_axis_tdata, 0);
        chk("rst_sent", pkt_sent_cnt, 0);
        chk("rst_drop", pkt_drop_cnt, 0);
        chk("rst_level", fifo_level, 0);
        chk("tuser", m_axis_tuser, 0);
        s_axis_tvalid = '0;
        aresetn       = 1'b1;
        repeat (2) step();

        // single 9-beat packet, latency from tlast to first output beat
        enq(0, 9);
        drain("t1");
        chk("t1_latency", first_out_cyc - tlast_cyc, 2);
        chk("t1_beats", out_beats, 9);
        chk("t1_sent", pkt_sent_cnt, 1);
        chk("t1_gaps", gap_cnt, 0);

        // oversize drops around the MAX_PKT boundary, plus single-beat packet
        enq(1, 40);
        enq(1, 3);
        drain("t2a");
        chk("t2_drop_first", pkt_drop_cnt, 1);
        chk("t2_sent_first", pkt_sent_cnt, 2);
        enq(1, 32);
        enq(1, 33);
        enq(1, 1);
        drain("t2b");
        chk("t2_drop", pkt_drop_cnt, 2);
        chk("t2_drop_model", pkt_drop_cnt, exp_drop);
        chk("t2_sent", pkt_sent_cnt, 4);
        chk("t2_level", fifo_level, 0);

        // both channels continuously valid: grants alternate starting with ch0
        grant_log.delete();
        for (int p = 0; p < 4; p++) begin
            enq(0, 4);
            enq(1, 4);
        end
        drain("t3");
        chk("t3_pkts", grant_log.size(), 8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++) chk("t3_rr_order", grant_log[i], i % 2);
        chk("t3_sent", pkt_sent_cnt, exp_sent);

        // tx_enable gating
        tx_enable = 1'b0;
        base      = out_beats;
        s0        = exp_sent;
        enq(0, 5);
        enq(0, 3);
        repeat (30) step();
        chk("t4_gated", out_beats - base, 0);
        tx_enable = 1'b1;
        n = 0;
        while (out_beats == base && n < 20) begin
            step();
            n++;
        end
        tx_enable = 1'b0;
        repeat (20) step();
        chk("t4_midpkt_beats", out_beats - base, 5);
        chk("t4_midpkt_sent", pkt_sent_cnt, s0 + 1);
        tx_enable = 1'b1;
        drain("t4");
        chk("t4_all_beats", out_beats - base, 8);
        chk("t4_sent", pkt_sent_cnt, s0 + 2);

        // backpressure until full, then release
        m_axis_tready = 1'b0;
        base          = out_beats;
        for (int p = 0; p < 8; p++) enq(0, 10);
        n = 0;
        while (fifo_level != DEPTH && n < 500) begin
            step();
            n++;
        end
        chk("t5_full_level", fifo_level, DEPTH);
        repeat (3) step();
        chk("t5_full_ready", s_axis_tready, 0);
        chk("t5_full_hold", fifo_level, DEPTH);
        chk("t5_no_out", out_beats - base, 0);
        m_axis_tready = 1'b1;
        drain("t5");
        chk("t5_beats", out_beats - base, 80);
        chk("t5_level", fifo_level, 0);
        chk("t5_sent", pkt_sent_cnt, exp_sent);

        // reset mid-packet with 20 beats buffered
        enq(0, 30);
        n = 0;
        while (fifo_level != 20 && n < 100) begin
            step();
            n++;
        end
        chk("t6_pre_level", fifo_level, 20);
        aresetn = 1'b0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            pend[ch].delete();
            cur[ch].delete();
        end
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        #1;
        chk("t6_m_tvalid", m_axis_tvalid, 0);
        chk("t6_m_tdata", m_axis_tdata, 0);
        chk("t6_s_tready", s_axis_tready, 0);
        chk("t6_level", fifo_level, 0);
        chk("t6_sent", pkt_sent_cnt, 0);
        chk("t6_drop", pkt_drop_cnt, 0);
        exp_q.delete();
        mid_out    = 1'b0;
        prev_stall = 1'b0;
        exp_sent   = 0;
        exp_drop   = 0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        repeat (2) step();
        base = out_beats;
        enq(0, 2);
        drain("t6");
        chk("t6_post_beats", out_beats - base, 2);
        chk("t6_post_sent", pkt_sent_cnt, 1);
        chk("t6_post_drop", pkt_drop_cnt, 0);
        chk("t6_post_level", fifo_level, 0);

        chk("no_gaps", gap_cnt, 0);
        chk("hold_stable", hold_err, 0);
        chk("one_ready", multi_rdy, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
